// File: rtl/sram_port_arbiter.sv
// Shares one sram-like bus port between the fetch requester (inst_*) and the
// load/store requester (data_*). Both sides use a req/addr_ok then data_ok
// handshake. An in-order owner FIFO records who issued each accepted request,
// so every bus response goes back to the right requester.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   inst_*_i / inst_*_o  fetch requester (req, wr, size, wstrb, addr, wdata / addr_ok, data_ok, rdata)
//   data_*_i / data_*_o  load/store requester, same signal set
//   bus_*_o / bus_*_i    shared port (req and fields out; addr_ok, data_ok, rdata in)
//   unexp_resp_o         sticky flag: a bus response arrived with no owner outstanding
module sram_port_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [1:0]  bus_size_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_addr_ok_i,
  input  logic        bus_data_ok_i,
  input  logic [31:0] bus_rdata_i,
  output logic        unexp_resp_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned StvW = $clog2(StarveLimit + 1);

  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [StvW-1:0] StvMax  = StvW'(StarveLimit);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

  lock_e           lock_q, lock_d;
  logic            sel_q, sel_d;          // 0: inst, 1: data
  logic            owner_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StvW-1:0] starve_q, starve_d;
  logic            unexp_q, unexp_d;

  logic fifo_full, fifo_empty, sel_free, sel, bus_req, accept, pop, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    fifo_full  = (cnt_q == CntMax);
    fifo_empty = (cnt_q == '0);
    // Data has priority unless inst has waited through StarveLimit data grants.
    sel_free   = data_req_i & ~(inst_req_i & (starve_q == StvMax));
    sel        = (lock_q == StLocked) ? sel_q : sel_free;
    // Full blocks new requests even if a response pops this cycle.
    bus_req    = ~reset & (inst_req_i | data_req_i) & ~fifo_full;
    accept     = bus_req & bus_addr_ok_i;
    pop        = ~reset & bus_data_ok_i & ~fifo_empty;
    head       = owner_q[rd_ptr_q];

    bus_req_o      = bus_req;
    inst_addr_ok_o = accept & ~sel;
    data_addr_ok_o = accept & sel;
    inst_data_ok_o = pop & ~head;
    data_data_ok_o = pop & head;
    inst_rdata_o   = bus_rdata_i;
    data_rdata_o   = bus_rdata_i;
    unexp_resp_o   = unexp_q;
  end

  always_comb begin
    bus_wr_o    = 1'b0;
    bus_size_o  = '0;
    bus_wstrb_o = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if (bus_req) begin
      if (sel) begin
        bus_wr_o    = data_wr_i;
        bus_size_o  = data_size_i;
        bus_wstrb_o = data_wstrb_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_wr_o    = inst_wr_i;
        bus_size_o  = inst_size_i;
        bus_wstrb_o = inst_wstrb_i;
        bus_addr_o  = inst_addr_i;
        bus_wdata_o = inst_wdata_i;
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    sel_d  = sel_q;
    unique case (lock_q)
      StUnlocked: begin
        // A request left pending must keep its owner until the port takes it.
        if (bus_req && !bus_addr_ok_i) begin
          lock_d = StLocked;
          sel_d  = sel;
        end
      end
      StLocked: begin
        if (accept) lock_d = StUnlocked;
      end
      default: lock_d = StUnlocked;
    endcase
  end

  always_comb begin
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    starve_d = starve_q;
    if (!inst_req_i || inst_addr_ok_o) begin
      starve_d = '0;
    end else if (data_addr_ok_o && (starve_q != StvMax)) begin
      starve_d = starve_q + StvW'(1);
    end

    unexp_d = unexp_q | (bus_data_ok_i & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q   <= StUnlocked;
      sel_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      unexp_q  <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      unexp_q  <= unexp_d;
    end
  end

  // Owner slots need no reset; the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept) owner_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter (MaxOutstanding=2, StarveLimit=4).
module tb_sram_port_arbiter;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h0000_1000;
  localparam logic [31:0] IW = 32'hcafe_f00d;
  localparam logic [31:0] DW = 32'hdead_beef;

  logic        clk;
  logic        reset;
  logic        inst_req, data_req;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        unexp_resp;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(
    .MaxOutstanding(2),
    .StarveLimit   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_req_i    (inst_req),
    .inst_wr_i     (1'b0),
    .inst_size_i   (2'd2),
    .inst_wstrb_i  (4'hf),
    .inst_addr_i   (IA),
    .inst_wdata_i  (IW),
    .inst_addr_ok_o(inst_addr_ok),
    .inst_data_ok_o(inst_data_ok),
    .inst_rdata_o  (inst_rdata),
    .data_req_i    (data_req),
    .data_wr_i     (1'b1),
    .data_size_i   (2'd2),
    .data_wstrb_i  (4'h3),
    .data_addr_i   (DA),
    .data_wdata_i  (DW),
    .data_addr_ok_o(data_addr_ok),
    .data_data_ok_o(data_data_ok),
    .data_rdata_o  (data_rdata),
    .bus_req_o     (bus_req),
    .bus_wr_o      (bus_wr),
    .bus_size_o    (bus_size),
    .bus_wstrb_o   (bus_wstrb),
    .bus_addr_o    (bus_addr),
    .bus_wdata_o   (bus_wdata),
    .bus_addr_ok_i (bus_addr_ok),
    .bus_data_ok_i (bus_data_ok),
    .bus_rdata_i   (bus_rdata),
    .unexp_resp_o  (unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  in;     // {reset, inst_req, data_req, bus_addr_ok, bus_data_ok}
    logic [31:0] rdata;
    logic [5:0]  exp;    // {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, unexp}
    logic [31:0] baddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [4:0] in, input logic [31:0] rdata,
                     input logic [5:0] exp, input logic [31:0] baddr);
    vec_t v;
    v.in    = in;
    v.rdata = rdata;
    v.exp   = exp;
    v.baddr = baddr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic dr, input logic aok,
                       input logic dok, input logic [31:0] rd);
    reset       = r;
    inst_req    = ir;
    data_req    = dr;
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset forces every handshake output low.
    add(5'b11111, 32'h0,         6'b000000, 32'h0);
    // Lone fetch, response two cycles later.
    add(5'b01010, 32'h0,         6'b110000, IA);
    add(5'b00000, 32'h0,         6'b000000, 32'h0);
    add(5'b00001, 32'h0280_0000, 6'b000100, 32'h0);
    // Simultaneous requests: data first, then inst; responses in that order.
    add(5'b01110, 32'h0,         6'b101000, DA);
    add(5'b01010, 32'h0,         6'b110000, IA);
    add(5'b00001, 32'h1111_1111, 6'b000010, 32'h0);
    add(5'b00001, 32'h2222_2222, 6'b000100, 32'h0);
    // Starvation: four data grants, fifth goes to inst.
    add(5'b01110, 32'h0,         6'b101000, DA);
    add(5'b01111, 32'h3333_3333, 6'b101010, DA);
    add(5'b01111, 32'h4444_4444, 6'b101010, DA);
    add(5'b01111, 32'h5555_5555, 6'b101010, DA);
    add(5'b01111, 32'h6666_6666, 6'b110010, IA);
    add(5'b00001, 32'h7777_7777, 6'b000100, 32'h0);
    // Lock holding data while inst rises.
    add(5'b00100, 32'h0,         6'b100000, DA);
    add(5'b01100, 32'h0,         6'b100000, DA);
    add(5'b01100, 32'h0,         6'b100000, DA);
    add(5'b01110, 32'h0,         6'b101000, DA);
    // Lock holding inst while data (normally higher priority) rises.
    add(5'b01000, 32'h0,         6'b100000, IA);
    add(5'b01100, 32'h0,         6'b100000, IA);
    add(5'b01110, 32'h0,         6'b110000, IA);
    // FIFO full: blocked even with a same-cycle pop, free the cycle after.
    add(5'b01110, 32'h0,         6'b000000, 32'h0);
    add(5'b01111, 32'h8888_8888, 6'b000010, 32'h0);
    add(5'b01110, 32'h0,         6'b101000, DA);
    // Reset with two outstanding, then a stray response.
    add(5'b11111, 32'h0,         6'b000000, 32'h0);
    add(5'b00001, 32'h9999_9999, 6'b000000, 32'h0);
    add(5'b00000, 32'h0,         6'b000001, 32'h0);
    add(5'b01010, 32'h0,         6'b110001, IA);
    add(5'b10000, 32'h0,         6'b000001, 32'h0);
    add(5'b00000, 32'h0,         6'b000000, 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].in[4], vq[i].in[3], vq[i].in[2], vq[i].in[1], vq[i].in[0], vq[i].rdata);
      #1;
      check($sformatf("v%0d bus_req", i),      32'(bus_req),      32'(vq[i].exp[5]));
      check($sformatf("v%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(vq[i].exp[4]));
      check($sformatf("v%0d data_addr_ok", i), 32'(data_addr_ok), 32'(vq[i].exp[3]));
      check($sformatf("v%0d inst_data_ok", i), 32'(inst_data_ok), 32'(vq[i].exp[2]));
      check($sformatf("v%0d data_data_ok", i), 32'(data_data_ok), 32'(vq[i].exp[1]));
      check($sformatf("v%0d unexp_resp", i),   32'(unexp_resp),   32'(vq[i].exp[0]));
      check($sformatf("v%0d bus_addr", i),     bus_addr,          vq[i].baddr);
      check($sformatf("v%0d inst_rdata", i),   inst_rdata,        vq[i].rdata);
      check($sformatf("v%0d data_rdata", i),   data_rdata,        vq[i].rdata);
    end

    // Data stalls three cycles; all write fields stay the data requester's.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, (c > 0), 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      check($sformatf("stall%0d bus_wr", c),    32'(bus_wr),       32'd1);
      check($sformatf("stall%0d bus_size", c),  32'(bus_size),     32'd2);
      check($sformatf("stall%0d bus_wstrb", c), 32'(bus_wstrb),    32'h3);
      check($sformatf("stall%0d bus_wdata", c), bus_wdata,         DW);
      check($sformatf("stall%0d bus_addr", c),  bus_addr,          DA);
      check($sformatf("stall%0d addr_ok", c),   32'({inst_addr_ok, data_addr_ok}), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("stall accept data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("stall accept inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("inst accept inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("inst bus_wr",              32'(bus_wr),       32'd0);
    check("inst bus_wstrb",           32'(bus_wstrb),    32'hf);
    check("inst bus_wdata",           bus_wdata,         IW);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'habcd_0001);
    #1;
    check("resp1 data_data_ok", 32'(data_data_ok), 32'd1);
    check("resp1 inst_data_ok", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'habcd_0002);
    #1;
    check("resp2 inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("resp2 data_data_ok", 32'(data_data_ok), 32'd0);
    check("resp2 inst_rdata",   inst_rdata,        32'habcd_0002);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("drained unexp_resp", 32'(unexp_resp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
